adder_master: RTL
=================

ADDER_MASTER -- requirements
Module: adder_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand, result and AXI data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: AXI address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0: base address of the adder slave register map.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256: watchdog limit per AXI channel wait.
REQ-005 SHALL have ports as follows (clock and reset first):
- m1_axi_aclk  in  1  single clock.
- m1_axi_areset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to compute op_a+op_b.
- op_a  in  DATA_WIDTH  operand A.
- op_b  in  DATA_WIDTH  operand B.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- sum  out  DATA_WIDTH  result read from offset 8.
- overflow  out  1  bit 0 of the word read from offset 12.
- error  out  1  slave error response or timeout; valid with done.
- AXI4-Lite master ports (m1_axi_ prefix): awaddr/araddr ADDR_WIDTH out; awvalid, wvalid, bready, arvalid, rready out 1; wdata DATA_WIDTH out; wstrb DATA_WIDTH/8 out; awready, wready, bvalid, arready, rvalid in 1; bresp, rresp in 2; rdata DATA_WIDTH in.

Function
REQ-006 SHALL use FSM states IDLE, WR_A, WR_B, RD_SUM, RD_OVF and DONE, with each write state covering its address/data and response phases.
REQ-007 SHALL, in IDLE, on start=1 capture op_a/op_b into internal registers, set busy=1 on the next cycle and enter WR_A; start SHALL be ignored while busy=1.
REQ-008 SHALL, in WR_A, drive awaddr=BASE_ADDR+0, wdata=captured A, wstrb all ones, and assert awvalid and wvalid together.
REQ-009 SHALL deassert awvalid and wvalid independently, each on the cycle after its own ready is sampled high; both SHALL accept ready in the same cycle.
REQ-010 SHALL keep awaddr/wdata stable while the corresponding valid is high.
REQ-011 SHALL, after both handshakes, assert bready until bvalid is sampled, then enter the next state; WR_B SHALL behave identically with offset 4 and captured B.
REQ-012 SHALL, in RD_SUM, assert arvalid with araddr=BASE_ADDR+8 until arready, then assert rready until rvalid, and latch rdata into sum.
REQ-013 SHALL perform RD_OVF the same way at offset 12 and latch rdata[0] into overflow.
REQ-014 SHALL treat bresp or rresp with bit 1 set (SLVERR/DECERR) as an error: set a sticky error flag and continue the sequence.
REQ-015 SHALL, in DONE, pulse done for exactly one cycle, drive error from the sticky flag, clear busy and return to IDLE.
REQ-016 SHALL hold sum, overflow and error stable until the next start is accepted.
REQ-017 SHALL complete in a minimum of 11 cycles from start to done with zero-wait-state slave handshakes.

Reset
REQ-018 SHALL, on m1_axi_areset=1, immediately drive all valid/ready outputs, busy, done, error, overflow and sum to 0, set awaddr/araddr/wdata to 0 and wstrb to all ones, and force the FSM to IDLE.
REQ-019 SHALL abandon any transaction in flight on reset, including mid-handshake, without producing a done pulse.

Configuration
REQ-020 SHALL, with ADDER_MASTER_TIMEOUT_EN defined, count cycles that any valid or bready/rready waits without handshake; on reaching TIMEOUT_CYCLES it SHALL drop all AXI valids/readies, set error and go to DONE.
REQ-021 SHALL, without ADDER_MASTER_TIMEOUT_EN, omit the counter and wait indefinitely for handshakes.

Structure
REQ-022 SHALL use package adder_master_pkg to hold the register offsets (OPA=0, OPB=4, SUM=8, OVF=12), the FSM state enum and the AXI response codes (OKAY, EXOKAY, SLVERR, DECERR).
REQ-023 SHALL place the watchdog in sub-module adder_master_timeout (clear, enable and expired ports), instantiated only under ADDER_MASTER_TIMEOUT_EN.

Verification
REQ-024 SHALL cover these directed scenarios:
- Zero-wait slave, op_a=5, op_b=7 -> writes 5@0 then 7@4; reads @8 then @12; sum=12, overflow=0, error=0; done 11 cycles after start.
- op_a=0xFFFFFFFF, op_b=1, slave returns overflow word 1 -> sum=0, overflow=1.
- awready 3 cycles before wready -> awvalid drops first, wvalid stays high until wready; exactly one write per offset.
- rresp=2'b10 on the sum read -> sequence continues to RD_OVF; done with error=1.
- With macro, arready held low 300 cycles -> arvalid drops at cycle 256, done with error=1; without macro, still waiting.
- Reset asserted during WR_B awaiting bvalid -> all outputs 0 immediately, no done; a new start runs a full clean sequence.

Source files
------------

// File: rtl/adder_master_pkg.sv
// rtl/adder_master_pkg.sv - register offsets, FSM states and AXI response codes for adder_master
package adder_master_pkg;

  localparam int unsigned OFF_OPA = 0;
  localparam int unsigned OFF_OPB = 4;
  localparam int unsigned OFF_SUM = 8;
  localparam int unsigned OFF_OVF = 12;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    RD_SUM,
    RD_OVF,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/adder_master_timeout.sv
// rtl/adder_master_timeout.sv - per-wait watchdog; expires after TIMEOUT_CYCLES stalled cycles
module adder_master_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic m1_axi_aclk,
  input  logic m1_axi_areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count holds the number of stalled cycles already seen before the current one.
  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/adder_master.sv
// rtl/adder_master.sv - AXI4-Lite master: writes A and B, reads sum and overflow from an adder slave
// Optional watchdog on every AXI wait: define ADDER_MASTER_TIMEOUT_EN.
module adder_master
  import adder_master_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   sum,
  output logic                    overflow,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("adder_master: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  err_q;
  logic                  timeout_hit;

  assign m1_axi_wstrb = '1;

`ifdef ADDER_MASTER_TIMEOUT_EN
  logic wait_any;
  logic hs_any;

  assign wait_any = m1_axi_awvalid | m1_axi_wvalid | m1_axi_bready | m1_axi_arvalid | m1_axi_rready;
  assign hs_any   = (m1_axi_awvalid & m1_axi_awready) | (m1_axi_wvalid & m1_axi_wready) |
                    (m1_axi_bready & m1_axi_bvalid) | (m1_axi_arvalid & m1_axi_arready) |
                    (m1_axi_rready & m1_axi_rvalid);

  adder_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .m1_axi_aclk  (m1_axi_aclk),
    .m1_axi_areset(m1_axi_areset),
    .clear        (hs_any),
    .enable       (wait_any),
    .expired      (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      state          <= IDLE;
      b_q            <= '0;
      err_q          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      overflow       <= 1'b0;
      sum            <= '0;
      m1_axi_awaddr  <= '0;
      m1_axi_awvalid <= 1'b0;
      m1_axi_wdata   <= '0;
      m1_axi_wvalid  <= 1'b0;
      m1_axi_bready  <= 1'b0;
      m1_axi_araddr  <= '0;
      m1_axi_arvalid <= 1'b0;
      m1_axi_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (timeout_hit) begin
        m1_axi_awvalid <= 1'b0;
        m1_axi_wvalid  <= 1'b0;
        m1_axi_bready  <= 1'b0;
        m1_axi_arvalid <= 1'b0;
        m1_axi_rready  <= 1'b0;
        err_q          <= 1'b1;
        state          <= DONE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              // wdata itself holds the captured operand A for the first write.
              b_q            <= op_b;
              err_q          <= 1'b0;
              error          <= 1'b0;
              busy           <= 1'b1;
              m1_axi_awaddr  <= BASE_ADDR + ADDR_WIDTH'(OFF_OPA);
              m1_axi_wdata   <= op_a;
              m1_axi_awvalid <= 1'b1;
              m1_axi_wvalid  <= 1'b1;
              state          <= WR_A;
            end
          end
          WR_A, WR_B: begin
            if (!m1_axi_bready) begin
              if (m1_axi_awvalid && m1_axi_awready) m1_axi_awvalid <= 1'b0;
              if (m1_axi_wvalid && m1_axi_wready) m1_axi_wvalid <= 1'b0;
              if ((!m1_axi_awvalid || m1_axi_awready) && (!m1_axi_wvalid || m1_axi_wready))
                m1_axi_bready <= 1'b1;
            end else if (m1_axi_bvalid) begin
              m1_axi_bready <= 1'b0;
              if (resp_is_err(m1_axi_bresp)) err_q <= 1'b1;
              if (state == WR_A) begin
                m1_axi_awaddr  <= BASE_ADDR + ADDR_WIDTH'(OFF_OPB);
                m1_axi_wdata   <= b_q;
                m1_axi_awvalid <= 1'b1;
                m1_axi_wvalid  <= 1'b1;
                state          <= WR_B;
              end else begin
                m1_axi_araddr  <= BASE_ADDR + ADDR_WIDTH'(OFF_SUM);
                m1_axi_arvalid <= 1'b1;
                state          <= RD_SUM;
              end
            end
          end
          RD_SUM, RD_OVF: begin
            if (m1_axi_arvalid) begin
              if (m1_axi_arready) begin
                m1_axi_arvalid <= 1'b0;
                m1_axi_rready  <= 1'b1;
              end
            end else if (m1_axi_rvalid) begin
              m1_axi_rready <= 1'b0;
              if (resp_is_err(m1_axi_rresp)) err_q <= 1'b1;
              if (state == RD_SUM) begin
                sum            <= m1_axi_rdata;
                m1_axi_araddr  <= BASE_ADDR + ADDR_WIDTH'(OFF_OVF);
                m1_axi_arvalid <= 1'b1;
                state          <= RD_OVF;
              end else begin
                overflow <= m1_axi_rdata[0];
                state    <= DONE;
              end
            end
          end
          DONE: begin
            done  <= 1'b1;
            error <= err_q;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
